// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared divide-FSM states, hazard classes and hazard priority for the pipeline controller.
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int LOAD_W = 4;
  localparam int CNT_W = 32;
  typedef enum logic [1:0] {IDLE, DIV_START, DIV_WAIT, DIV_DONE} div_state_t;
  typedef enum logic [2:0] {HZ_NONE, HZ_EXC, HZ_DMEM, HZ_DIV, HZ_LOAD_USE, HZ_IMEM} hazard_t;
  // Highest-priority hazard wins; the rest of the controller only looks at the winner.
  function automatic hazard_t pick_hazard(input logic exc, input logic dmem, input logic div,
                                          input logic lu, input logic imem);
    return exc ? HZ_EXC : dmem ? HZ_DMEM : div ? HZ_DIV : lu ? HZ_LOAD_USE : imem ? HZ_IMEM : HZ_NONE;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load still in EXE.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [LOAD_W-1:0] load_type,
  input  logic              wreg,
  input  logic [REG_W-1:0]  dst,
  output logic              hit
);
  always_comb
    hit = |load_type && wreg && |dst && ((use_rs && rs == dst) || (use_rt && rt == dst));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush generation, multi-cycle divide sequencing and stall cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  ID_rs,
  input  logic [REG_W-1:0]  ID_rt,
  input  logic              ID_use_rs,
  input  logic              ID_use_rt,
  input  logic [LOAD_W-1:0] ID_EXE_load_type_data,
  input  logic              ID_EXE_wreg_data,
  input  logic [REG_W-1:0]  ID_EXE_dst,
  input  logic              ID_EXE_is_div_data,
  input  logic              div_ready,
  input  logic              exc_flush,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  output logic              PC_Stall,
  output logic              IF_ID_Stall,
  output logic              ID_EXE_Stall,
  output logic              EXE_MEM_Stall,
  output logic              MEM_WB_Stall,
  output logic              IF_ID_Flush,
  output logic              ID_EXE_Flush,
  output logic              EXE_MEM_Flush,
  output logic              MEM_WB_Flush,
  output logic              div_start,
  output logic              div_abort,
  output logic [CNT_W-1:0]  stall_cnt
);
  div_state_t state;
  hazard_t hz;
  logic lu_hit, div_haz;
  load_use_detect u_lu (
    .rs(ID_rs),
    .rt(ID_rt),
    .use_rs(ID_use_rs),
    .use_rt(ID_use_rt),
    .load_type(ID_EXE_load_type_data),
    .wreg(ID_EXE_wreg_data),
    .dst(ID_EXE_dst),
    .hit(lu_hit)
  );
  // A divide arriving in EXE is held from its first cycle so it cannot slip past before launch.
  always_comb begin
    div_haz = (state == IDLE && ID_EXE_is_div_data) || state == DIV_START ||
              (state == DIV_WAIT && !div_ready);
    hz = rst ? HZ_NONE : pick_hazard(exc_flush, dmem_busy, div_haz, lu_hit, imem_busy);
    PC_Stall = hz != HZ_NONE && hz != HZ_EXC;
    IF_ID_Stall = hz == HZ_DMEM || hz == HZ_DIV || hz == HZ_LOAD_USE;
    ID_EXE_Stall = hz == HZ_DMEM || hz == HZ_DIV;
    EXE_MEM_Stall = hz == HZ_DMEM;
    MEM_WB_Stall = hz == HZ_DMEM;
    IF_ID_Flush = (hz == HZ_EXC || hz == HZ_IMEM) && !IF_ID_Stall;
    ID_EXE_Flush = (hz == HZ_EXC || hz == HZ_LOAD_USE) && !ID_EXE_Stall;
    EXE_MEM_Flush = (hz == HZ_EXC || hz == HZ_DIV) && !EXE_MEM_Stall;
    MEM_WB_Flush = hz == HZ_EXC && !MEM_WB_Stall;
    div_abort = hz == HZ_EXC;
    div_start = !rst && !exc_flush && state == DIV_START;
  end
  // DIV_DONE waits for EXE to move so a held divide is not launched twice.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(PC_Stall);
      if (exc_flush) state <= IDLE;
      else
        case (state)
          IDLE:      if (ID_EXE_is_div_data) state <= DIV_START;
          DIV_START: state <= DIV_WAIT;
          DIV_WAIT:  if (div_ready) state <= DIV_DONE;
          DIV_DONE:  if (!ID_EXE_Stall) state <= IDLE;
        endcase
    end
endmodule
